glyph_slot_renderer: RTL

//  Parametrised successor to the fixed lamp/rotor drawing datapath. Holds N_SLOTS

---
 rtl/glyph_slot_renderer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/glyph_slot_renderer.sv
// glyph_slot_renderer: glyph slot store with a scan FSM that redraws slots one pixel per cycle
module glyph_slot_renderer #(
    parameter int N_SLOTS = 32,
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 5,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int MODE    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(N_SLOTS)-1:0]   wr_slot,
    input  logic [4:0]                   wr_code,
    input  logic [XW-1:0]                wr_x,
    input  logic [YW-1:0]                wr_y,
    input  logic [CW-1:0]                wr_colour,
    input  logic [CW-1:0]                bg_colour,
    input  logic                         force_refresh,
    output logic [4:0]                   glyph_code_o,
    input  logic [GLYPH_W*GLYPH_H-1:0]   glyph_bits_i,
    output logic [XW-1:0]                x,
    output logic [YW-1:0]                y,
    output logic [CW-1:0]                colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int SAW = $clog2(N_SLOTS);
    localparam int GB = GLYPH_W * GLYPH_H;
    localparam int RW = $clog2(GLYPH_H + 1);
    localparam int CL = $clog2(GLYPH_W + 1);
    localparam bit REFRESH = MODE != 0;

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAW} state_t;

    state_t state, nxt;
    logic [4:0] code [N_SLOTS];
    logic [XW-1:0] ox [N_SLOTS];
    logic [YW-1:0] oy [N_SLOTS];
    logic [CW-1:0] fg [N_SLOTS];
    logic [N_SLOTS-1:0] dirty;
    logic [SAW-1:0] ptr;
    logic [RW-1:0] row;
    logic [CL-1:0] col;
    logic [4:0] s_code;
    logic [XW-1:0] s_x, x_h;
    logic [YW-1:0] s_y, y_h;
    logic [CW-1:0] s_fg, c_h;
    logic [GB-1:0] bits;

    wire last = ptr == SAW'(N_SLOTS - 1);
    wire draw_slot = dirty[ptr] || REFRESH;
    wire last_col = col == CL'(GLYPH_W - 1);
    wire last_px = last_col && row == RW'(GLYPH_H - 1);
    wire slot_end = (state == SCAN && !draw_slot) || (state == DRAW && last_px);
    wire [XW-1:0] px = s_x + XW'(col);
    wire [YW-1:0] py = s_y + YW'(row);
    wire [CW-1:0] pc = (s_code <= 5'd25 && bits[GB-1]) ? s_fg : bg_colour;
    wire state_t sweep_next = (!last || REFRESH || |dirty) ? SCAN : IDLE;

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    // next-state: sweep slots, drawing dirty ones (or all in refresh mode)
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (REFRESH || |dirty) ? SCAN : IDLE;
            SCAN:    nxt = draw_slot ? FETCH : sweep_next;
            FETCH:   nxt = DRAW;
            DRAW:    nxt = last_px ? sweep_next : DRAW;
            default: nxt = IDLE;
        endcase
    end

    // outputs: live pixel while drawing, otherwise hold the last drawn pixel
    always_comb begin
        busy = state != IDLE;
        plot = state == DRAW;
        glyph_code_o = state == FETCH ? code[ptr] : s_code;
        x = plot ? px : x_h;
        y = plot ? py : y_h;
        colour = plot ? pc : c_h;
    end

    // slot store; a write or force_refresh beats the FETCH clearing dirty
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                code[i] <= 5'd31;
                ox[i] <= '0;
                oy[i] <= '0;
                fg[i] <= '0;
            end
            dirty <= '1;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (wr_en && wr_slot == SAW'(i)) begin
                    code[i] <= wr_code;
                    ox[i] <= wr_x;
                    oy[i] <= wr_y;
                    fg[i] <= wr_colour;
                end
                dirty[i] <= force_refresh || (wr_en && wr_slot == SAW'(i)) ||
                            (dirty[i] && !(state == FETCH && ptr == SAW'(i)));
            end
        end

    // slot pointer, snapshot of the slot being drawn and pixel walk
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ptr <= '0;
            row <= '0;
            col <= '0;
            s_code <= 5'd31;
            s_x <= '0;
            s_y <= '0;
            s_fg <= '0;
            bits <= '0;
            x_h <= '0;
            y_h <= '0;
            c_h <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= slot_end && last;
            if (slot_end) ptr <= last ? '0 : ptr + SAW'(1);
            if (state == FETCH) begin
                s_code <= code[ptr];
                s_x <= ox[ptr];
                s_y <= oy[ptr];
                s_fg <= fg[ptr];
                bits <= glyph_bits_i;
                row <= '0;
                col <= '0;
            end
            if (state == DRAW) begin
                bits <= bits << 1;
                col <= last_col ? '0 : col + CL'(1);
                row <= last_col ? row + RW'(1) : row;
                x_h <= px;
                y_h <= py;
                c_h <= pc;
            end
        end
endmodule
